// File: rtl/x86_muldiv_if.sv
// Request/response bundle between an issuing core and the x86 multiply/divide unit.
interface x86_muldiv_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [1:0]       mode;
    logic             i_size;
    logic [WIDTH-1:0] op_lo;
    logic [WIDTH-1:0] op_hi;
    logic [WIDTH-1:0] op_src;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             cf_of;
    logic             div_err;

    modport master (
        output start, mode, i_size, op_lo, op_hi, op_src,
        input  busy, done, res_lo, res_hi, cf_of, div_err
    );

    modport slave (
        input  start, mode, i_size, op_lo, op_hi, op_src,
        output busy, done, res_lo, res_hi, cf_of, div_err
    );
endinterface

// File: rtl/x86_muldiv.sv
// Iterative x86 MUL/IMUL/DIV/IDIV: one result bit per CALC cycle on operand magnitudes,
// sign correction and flag/exception evaluation in FIX.
module x86_muldiv #(
    parameter int unsigned WIDTH = 16
) (
    input logic         clock_i,
    input logic         reset_i,
    x86_muldiv_if.slave bus
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e           state_q;
    logic             busy_q, done_q, cf_q, err_q;
    logic [WIDTH-1:0] res_lo_q, res_hi_q;
    logic             size_q, div_q, sgn_q, neg_q, rsn_q, ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [W2-1:0]    acc_q;
    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;

    // Accept-time operand conditioning: mask to N bits and take magnitudes.
    logic [WIDTH-1:0] mask_n, lo_raw, src_raw, lo_mag, src_mag, dhi_mag, dlo_mag;
    logic [W2-1:0]    mask_2n, dvd_raw, dvd_mag;
    logic             lo_sgn, src_sgn, dvd_sgn, sgn_mode, div_mode, neg_d, pre_ovf, src_zero;

    always_comb begin
        sgn_mode = bus.mode[0];
        div_mode = bus.mode[1];
        if (bus.i_size) begin
            mask_n  = '1;
            mask_2n = '1;
            lo_raw  = bus.op_lo;
            src_raw = bus.op_src;
            dvd_raw = {bus.op_hi, bus.op_lo};
            lo_sgn  = bus.op_lo[WIDTH-1];
            src_sgn = bus.op_src[WIDTH-1];
            dvd_sgn = bus.op_hi[WIDTH-1];
        end else begin
            mask_n  = WIDTH'(8'hFF);
            mask_2n = W2'(16'hFFFF);
            lo_raw  = WIDTH'(bus.op_lo[7:0]);
            src_raw = WIDTH'(bus.op_src[7:0]);
            dvd_raw = W2'({bus.op_hi[7:0], bus.op_lo[7:0]});
            lo_sgn  = bus.op_lo[7];
            src_sgn = bus.op_src[7];
            dvd_sgn = bus.op_hi[7];
        end
        lo_mag   = (sgn_mode && lo_sgn)  ? ((WIDTH'(0) - lo_raw) & mask_n)   : lo_raw;
        src_mag  = (sgn_mode && src_sgn) ? ((WIDTH'(0) - src_raw) & mask_n)  : src_raw;
        dvd_mag  = (sgn_mode && dvd_sgn) ? ((W2'(0) - dvd_raw) & mask_2n)    : dvd_raw;
        dhi_mag  = bus.i_size ? dvd_mag[W2-1:WIDTH] : WIDTH'(dvd_mag[15:8]);
        dlo_mag  = bus.i_size ? dvd_mag[WIDTH-1:0]  : WIDTH'(dvd_mag[7:0]);
        neg_d    = sgn_mode && ((div_mode ? dvd_sgn : lo_sgn) ^ src_sgn);
        // Unsigned quotient fits in N bits only if the dividend high half is below the divisor.
        pre_ovf  = dhi_mag >= src_mag;
        src_zero = (src_mag == '0);
    end

    // One iteration: MSB-first shift-add for multiply, restoring shift-subtract for divide.
    logic             msb, rem_ge;
    logic [W2-1:0]    acc_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_d, quo_d;

    always_comb begin
        msb    = size_q ? quo_q[WIDTH-1] : quo_q[7];
        acc_d  = {acc_q[W2-2:0], 1'b0} + (msb ? W2'(dsr_q) : W2'(0));
        rem_sh = {rem_q, msb};
        rem_ge = rem_sh >= {1'b0, dsr_q};
        rem_d  = rem_ge ? (rem_sh[WIDTH-1:0] - dsr_q) : rem_sh[WIDTH-1:0];
        quo_d  = {quo_q[WIDTH-2:0], rem_ge};
    end

    // Sign correction, flags and divide-exception check applied on the way into DONE.
    logic [W2-1:0]    mask_2q, prod_mag, prod;
    logic [WIDTH-1:0] mask_q, half, p_lo, p_hi, q_mag, q_fix, r_fix, fix_lo_d, fix_hi_d;
    logic             fix_cf_d, fix_err_d;

    always_comb begin
        mask_q   = size_q ? '1 : WIDTH'(8'hFF);
        mask_2q  = size_q ? '1 : W2'(16'hFFFF);
        half     = size_q ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(8'h80);
        prod_mag = acc_q & mask_2q;
        prod     = neg_q ? ((W2'(0) - prod_mag) & mask_2q) : prod_mag;
        p_lo     = size_q ? prod[WIDTH-1:0]  : WIDTH'(prod[7:0]);
        p_hi     = size_q ? prod[W2-1:WIDTH] : WIDTH'(prod[15:8]);
        q_mag    = quo_q & mask_q;
        q_fix    = neg_q ? ((WIDTH'(0) - q_mag) & mask_q) : q_mag;
        r_fix    = rsn_q ? ((WIDTH'(0) - rem_q) & mask_q) : rem_q;
        fix_lo_d  = '0;
        fix_hi_d  = '0;
        fix_cf_d  = 1'b0;
        fix_err_d = 1'b0;
        if (div_q) begin
            // A negative quotient may reach -2^(N-1); a positive one stops at 2^(N-1)-1.
            fix_err_d = ovf_q || (sgn_q && (neg_q ? (q_mag > half) : (q_mag >= half)));
            if (!fix_err_d) begin
                fix_lo_d = q_fix;
                fix_hi_d = r_fix;
            end
        end else begin
            fix_lo_d = p_lo;
            fix_hi_d = p_hi;
            if (sgn_q) begin
                fix_cf_d = size_q ? (prod[W2-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                  : (prod[15:8] != {8{prod[7]}});
            end else begin
                fix_cf_d = (p_hi != '0);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            cf_q     <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 1'b0;
            div_q    <= 1'b0;
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            rsn_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        size_q <= bus.i_size;
                        div_q  <= div_mode;
                        sgn_q  <= sgn_mode;
                        neg_q  <= neg_d;
                        rsn_q  <= sgn_mode && dvd_sgn;
                        ovf_q  <= pre_ovf;
                        cnt_q  <= bus.i_size ? CW'(WIDTH - 1) : CW'(7);
                        acc_q  <= '0;
                        rem_q  <= dhi_mag;
                        quo_q  <= div_mode ? dlo_mag : src_mag;
                        dsr_q  <= div_mode ? src_mag : lo_mag;
                        // Divide by zero skips the datapath and raises #DE next cycle.
                        if (div_mode && src_zero) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            err_q    <= 1'b1;
                            cf_q     <= 1'b0;
                            res_lo_q <= '0;
                            res_hi_q <= '0;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (div_q) begin
                        rem_q <= rem_d;
                    end else begin
                        acc_q <= acc_d;
                    end
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    state_q  <= S_DONE;
                    done_q   <= 1'b1;
                    res_lo_q <= fix_lo_d;
                    res_hi_q <= fix_hi_d;
                    cf_q     <= fix_cf_d;
                    err_q    <= fix_err_d;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.res_lo  = res_lo_q;
    assign bus.res_hi  = res_hi_q;
    assign bus.cf_of   = cf_q;
    assign bus.div_err = err_q;
endmodule
